// File: rtl/md_unit.sv
//==============================================================================
// Module   : md_unit
// Purpose  : Multi-cycle multiply/divide unit that owns the HI/LO registers.
//            Optional madd/maddu support is enabled with macro MD_MADD_EN.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module md_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] c_OP_MADD  = 4'd7;
    localparam logic [3:0] c_OP_MADDU = 4'd8;
`endif
    localparam logic [3:0] c_LAT_MUL  = 4'd5;
    localparam logic [3:0] c_LAT_DIV  = 4'd10;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state, w_nstate;
    logic [3:0]  r_cnt,   w_ncnt;
    logic        r_busy,  w_nbusy;
    logic [31:0] r_hi,    w_nhi;
    logic [31:0] r_lo,    w_nlo;
    logic [31:0] r_a, r_b;
    logic [3:0]  r_op;
    logic        w_latch;

    // Arithmetic works only on latched operands so a/b may change during RUN.
    logic [63:0] w_prod_s, w_prod_u;
    logic [31:0] w_dvd, w_dvs, w_uq, w_ur;
    logic        w_sdiv;
    logic [63:0] w_res;
    logic        w_res_wr;

    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed division runs on magnitudes; signs are restored afterwards.
    assign w_sdiv = (r_op == c_OP_DIV);
    assign w_dvd  = (w_sdiv && r_a[31]) ? (32'd0 - r_a) : r_a;
    assign w_dvs  = (w_sdiv && r_b[31]) ? (32'd0 - r_b) : r_b;
    assign w_uq   = w_dvd / w_dvs;
    assign w_ur   = w_dvd % w_dvs;

    always_comb begin
        w_res    = {r_hi, r_lo};
        w_res_wr = 1'b1;
        case (r_op)
            c_OP_MULT:  w_res = w_prod_s;
            c_OP_MULTU: w_res = w_prod_u;
            c_OP_DIV: begin
                w_res[31:0]  = (r_a[31] ^ r_b[31]) ? (32'd0 - w_uq) : w_uq;
                w_res[63:32] = r_a[31] ? (32'd0 - w_ur) : w_ur;
                w_res_wr     = (r_b != 32'd0);
            end
            c_OP_DIVU: begin
                w_res    = {w_ur, w_uq};
                w_res_wr = (r_b != 32'd0);
            end
`ifdef MD_MADD_EN
            // HI/LO cannot change during RUN, so the live value is the start value.
            c_OP_MADD:  w_res = {r_hi, r_lo} + w_prod_s;
            c_OP_MADDU: w_res = {r_hi, r_lo} + w_prod_u;
`endif
            default:    w_res_wr = 1'b0;
        endcase
    end

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_nbusy  = r_busy;
        w_nhi    = r_hi;
        w_nlo    = r_lo;
        w_latch  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (md_op)
                        c_OP_MULT, c_OP_MULTU
`ifdef MD_MADD_EN
                        , c_OP_MADD, c_OP_MADDU
`endif
                        : begin
                            w_latch  = 1'b1;
                            w_ncnt   = c_LAT_MUL;
                            w_nstate = S_RUN;
                            w_nbusy  = 1'b1;
                        end
                        c_OP_DIV, c_OP_DIVU: begin
                            w_latch  = 1'b1;
                            w_ncnt   = c_LAT_DIV;
                            w_nstate = S_RUN;
                            w_nbusy  = 1'b1;
                        end
                        c_OP_MTHI: w_nhi = a;
                        c_OP_MTLO: w_nlo = a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (r_cnt == 4'd1) begin
                    w_nstate = S_IDLE;
                    w_ncnt   = 4'd0;
                    w_nbusy  = 1'b0;
                    if (w_res_wr) begin
                        w_nhi = w_res[63:32];
                        w_nlo = w_res[31:0];
                    end
                end else begin
                    w_ncnt = r_cnt - 4'd1;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 4'd0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_busy  <= w_nbusy;
            r_hi    <= w_nhi;
            r_lo    <= w_nlo;
            if (w_latch) begin
                r_a  <= a;
                r_b  <= b;
                r_op <= md_op;
            end
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
//==============================================================================
// Module   : tb_md_unit
// Purpose  : Self-checking bench for md_unit against an arithmetic model of
//            HI/LO. Honours MD_MADD_EN the same way as the design.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Architectural result: latency in cycles (0 = immediate) and new {hi,lo}.
    function automatic void model(input logic [3:0] op, input logic [31:0] av,
                                  input logic [31:0] bv, output int lat,
                                  output logic [63:0] nv);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     q, r;
        sa  = $signed(av);
        sb  = $signed(bv);
        ua  = {32'd0, av};
        ub  = {32'd0, bv};
        nv  = {m_hi, m_lo};
        lat = 0;
        case (op)
            4'd1: begin lat = 5; nv = sa * sb; end
            4'd2: begin lat = 5; nv = ua * ub; end
            4'd3: begin
                lat = 10;
                if (bv != 0) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    nv = {r[31:0], q[31:0]};
                end
            end
            4'd4: begin
                lat = 10;
                if (bv != 0) nv = {av % bv, av / bv};
            end
            4'd5: nv[63:32] = av;
            4'd6: nv[31:0]  = av;
`ifdef MD_MADD_EN
            4'd7: begin lat = 5; nv = nv + sa * sb; end
            4'd8: begin lat = 5; nv = nv + ua * ub; end
`endif
            default: ;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op; optionally pulse a stray start at RUN cycle stray_at.
    task automatic do_op(input logic [3:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input int stray_at);
        int          lat;
        logic [63:0] nv;
        model(op, av, bv, lat, nv);
        start = 1'b1; md_op = op; a = av; b = bv;
        tick();
        start = 1'b0; a = $urandom; b = $urandom;
        for (int i = 1; i <= lat; i++) begin
            check("busy_run", {63'd0, busy}, 64'd1);
            check("hilo_hold", {hi, lo}, {m_hi, m_lo});
            if (i == stray_at) begin
                start = 1'b1;
                md_op = 4'($urandom_range(1, 8));
            end
            tick();
            start = 1'b0; a = $urandom; b = $urandom;
        end
        {m_hi, m_lo} = nv;
        check("busy_done", {63'd0, busy}, 64'd0);
        check("hilo_result", {hi, lo}, {m_hi, m_lo});
    endtask

    task automatic reset_during(input logic [3:0] op, input logic [31:0] av,
                                input logic [31:0] bv, input int cyc);
        start = 1'b1; md_op = op; a = av; b = bv;
        tick();
        start = 1'b0;
        for (int i = 1; i < cyc; i++) begin
            check("busy_pre_rst", {63'd0, busy}, 64'd1);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        check("busy_abort", {63'd0, busy}, 64'd0);
        check("hilo_abort", {hi, lo}, 64'd0);
        for (int i = 0; i < 10; i++) tick();
        check("no_late_wb", {busy, hi, lo}, 65'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        tick();
        tick();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        tick();

        do_op(4'd1, 32'hFFFF_FFFF, 32'd2, 0);
        check("mult_dir", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op(4'd2, 32'hFFFF_FFFF, 32'd2, 0);
        check("multu_dir", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 4);
        check("div_dir", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op(4'd5, 32'h1234_5678, 32'd0, 0);
        do_op(4'd4, 32'h0000_0077, 32'd0, 0);
        check("divu_zero", {hi, lo}, 64'h1234_5678_8000_0000);
        do_op(4'd0, 32'hDEAD_BEEF, 32'd3, 0);
        do_op(4'd12, 32'hDEAD_BEEF, 32'd3, 0);

        reset_during(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
        do_op(4'd6, 32'hA5A5_A5A5, 32'd0, 0);
        check("mtlo_after_rst", {hi, lo}, 64'h0000_0000_A5A5_A5A5);

        // Reset wins over a coincident start.
        start = 1'b1; md_op = 4'd5; a = 32'h5555_5555; reset = 1'b1;
        tick();
        start = 1'b0; reset = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
        check("rst_vs_start", {busy, hi, lo}, 65'd0);

        do_op(4'd5, 32'd0, 32'd0, 0);
        do_op(4'd6, 32'hFFFF_FFFF, 32'd0, 0);
        do_op(4'd8, 32'd1, 32'd1, 0);
`ifdef MD_MADD_EN
        check("maddu_dir", {hi, lo}, 64'h0000_0001_0000_0000);
`else
        check("maddu_noop", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

        for (int n = 0; n < 200; n++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(1, 8));
            do_op(op, rand_operand(), rand_operand(), $urandom_range(0, 12));
            if ($urandom_range(0, 4) == 0) tick();
        end
        reset_during(4'd3, $urandom, 32'd7, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port start, input, 1 bit: a one-cycle pulse from E stage marking a valid md_op.
REQ-004 The block SHALL have port md_op, input, 4 bits, with these codes:
- 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo;
- 7 madd, 8 maddu only when MD_MADD_EN is defined;
- all other codes are no-ops.
REQ-005 The block SHALL have port a, input, 32 bits: rs operand, already forwarded.
REQ-006 The block SHALL have port b, input, 32 bits: rt operand, already forwarded.
REQ-007 The block SHALL have port busy, output, 1 bit, registered: high while a multi-cycle operation is in flight.
REQ-008 The block SHALL have port hi, output, 32 bits: architectural HI register, read by mfhi.
REQ-009 The block SHALL have port lo, output, 32 bits: architectural LO register, read by mflo.

Function
REQ-010 The block SHALL have two states: IDLE and RUN.
REQ-011 In IDLE, start with md_op in {1,2,3,4,7,8} SHALL:
- latch a, b and md_op;
- load the cycle counter with 5 for mult, multu, madd and maddu, or 10 for div and divu;
- enter RUN, with busy high from the next cycle.
REQ-012 In RUN, the counter SHALL decrement each cycle; on the cycle it reaches 1, hi/lo SHALL take the result, busy SHALL fall and state SHALL return to IDLE.
REQ-013 Latency: busy SHALL be high for exactly N cycles after the start cycle; the updated hi/lo SHALL be visible in the first cycle busy is low.
REQ-014 mthi SHALL write hi = a, and mtlo SHALL write lo = a, at the next edge, without asserting busy.
REQ-015 start SHALL be ignored while busy is high; the hazard unit stalls D on (busy | start) whenever the D-stage instruction is an MD instruction.
REQ-016 hi/lo SHALL hold their old values throughout RUN; there are no partial updates.
REQ-017 mult/multu SHALL produce {hi,lo} = the 64-bit signed or unsigned product of a and b.
REQ-018 div/divu SHALL produce lo = quotient and hi = remainder:
- signed quotient truncates toward zero;
- remainder takes the sign of the dividend.
REQ-019 Division by zero SHALL leave hi/lo unchanged; the full latency and busy timing still apply.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo = 0x80000000, hi = 0x00000000.
REQ-021 Results SHALL be computed from the operands latched at start; changes on a/b during RUN SHALL have no effect.

Reset
REQ-022 Reset SHALL force hi = 0, lo = 0, busy = 0, state = IDLE and counter = 0.
REQ-023 Reset asserted during RUN SHALL abort the operation with no hi/lo writeback.
REQ-024 Reset asserted in the same cycle as start SHALL take priority; start is ignored.

Configuration
REQ-025 With macro MD_MADD_EN defined, md_op 7/8 SHALL compute {hi,lo} = {hi,lo} + the signed/unsigned product:
- latency 5;
- the 64-bit sum wraps modulo 2^64;
- the {hi,lo} value added is the one held at start.
REQ-026 Without MD_MADD_EN, md_op 7/8 SHALL be no-ops: no busy, no hi/lo change.

Verification
REQ-027 mult with a = 0xFFFFFFFF, b = 0x00000002 -> busy high for 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFE.
REQ-028 multu with a = 0xFFFFFFFF, b = 0x00000002 -> after 5 cycles, hi = 0x00000001, lo = 0xFFFFFFFE.
REQ-029 div with a = 0xFFFFFFF9 (-7), b = 2 -> busy high for 10 cycles, then lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; a second start pulsed at cycle 4 is ignored.
REQ-030 mthi 0x12345678, then divu with b = 0 -> after 10 cycles, hi = 0x12345678 and lo unchanged.
REQ-031 multu started, then reset at cycle 3 -> busy = 0 and hi = lo = 0 next cycle; a following mtlo 0xA5A5A5A5 updates lo in 1 cycle.
REQ-032 With MD_MADD_EN: hi = 0, lo = 0xFFFFFFFF, then maddu with a = 1, b = 1 -> hi = 0x00000001, lo = 0x00000000; without the macro, hi/lo are unchanged and busy stays low.
